// File: rtl/bilinear_upscale_2x_if.sv
// Pixel pull interface from the upstream reader and display-side output stream
// of the 2x bilinear upscaler.
//
// Handshake: frame_i_req is a read request. Upstream answers each request
// with frame_i_valid/frame_i_data exactly one cycle later. There is no
// backpressure in either direction. A valid that has no request in the
// previous cycle is meaningless and is ignored by the upscaler. On the output
// side, frame_o_valid marks a pixel and there is no ready. frame_o_hs and
// frame_o_vs are single-cycle framing pulses.
interface bilinear_upscale_2x_if #(
   parameter int DATA_WIDTH = 24
);
   logic                  frame_i_req;
   logic                  frame_i_valid;
   logic [DATA_WIDTH-1:0] frame_i_data;
   logic                  frame_o_vs;
   logic                  frame_o_hs;
   logic                  frame_o_valid;
   logic [DATA_WIDTH-1:0] frame_o_data;

   modport master (
      output frame_i_req,
      input  frame_i_valid,
      input  frame_i_data,
      output frame_o_vs,
      output frame_o_hs,
      output frame_o_valid,
      output frame_o_data
   );

   modport slave (
      input  frame_i_req,
      output frame_i_valid,
      output frame_i_data,
      input  frame_o_vs,
      input  frame_o_hs,
      input  frame_o_valid,
      input  frame_o_data
   );
endinterface

// File: rtl/bilinear_upscale_2x.sv
// 2x bilinear upscaler: pulls a half-resolution frame row by row into two
// ping-pong line buffers and streams the doubled frame with hs/vs framing.
module bilinear_upscale_2x #(
   parameter int DATA_WIDTH  = 24,
   parameter int RGB_R_WIDTH = 8,
   parameter int RGB_G_WIDTH = 8,
   parameter int RGB_B_WIDTH = 8,
   parameter int IN_H_PIXEL  = 960,
   parameter int IN_V_PIXEL  = 540,
   parameter int HBLANK      = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   frame_start,
   output logic                   busy,
   bilinear_upscale_2x_if.master  bus,
   output logic [2:0]             dbg_state_o
);

   localparam int CW   = (IN_H_PIXEL > 1) ? $clog2(IN_H_PIXEL) : 1;
   localparam int PW   = CW + 1;
   localparam int YW   = (IN_V_PIXEL > 1) ? $clog2(IN_V_PIXEL) : 1;
   localparam int ROWW = YW + 1;
   localparam int BKW  = (HBLANK > 1) ? $clog2(HBLANK) : 1;
   localparam int QW   = $clog2(IN_H_PIXEL + 1);
   localparam int MW0  = (RGB_R_WIDTH > RGB_G_WIDTH) ? RGB_R_WIDTH : RGB_G_WIDTH;
   localparam int MW   = (MW0 > RGB_B_WIDTH) ? MW0 : RGB_B_WIDTH;
   localparam int B_LO = 0;
   localparam int G_LO = RGB_B_WIDTH;
   localparam int R_LO = RGB_B_WIDTH + RGB_G_WIDTH;

   localparam logic [CW-1:0]   COL_LAST   = CW'(IN_H_PIXEL - 1);
   localparam logic [PW-1:0]   PIX_LAST   = PW'(2 * IN_H_PIXEL - 1);
   localparam logic [YW-1:0]   Y_LAST     = YW'(IN_V_PIXEL - 1);
   localparam logic [ROWW-1:0] ROW_LAST   = ROWW'(2 * IN_V_PIXEL - 1);
   localparam logic [BKW-1:0]  BLANK_LAST = BKW'(HBLANK - 1);
   localparam logic [QW-1:0]   REQ_ROW    = QW'(IN_H_PIXEL);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PRELOAD   = 3'd1,
      S_ROW_HS    = 3'd2,
      S_ROW_PIX   = 3'd3,
      S_ROW_BLANK = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic              sel_q, sel_d;
   logic [ROWW-1:0]   row_q, row_d;
   logic [PW-1:0]     pix_q, pix_d;
   logic [BKW-1:0]    blank_q, blank_d;
   logic              busy_q;

   logic [QW-1:0]     req_left_q;
   logic [CW-1:0]     wr_col_q;
   logic              wr_buf_q;
   logic              req_d1_q;
   logic              req;
   logic              wr_en;
   logic              load_fetch;
   logic              fetch_buf;
   logic              accept;
   logic [ROWW-1:0]   row_nx;

   logic                  vs_q, hs_q, valid_q;
   logic [DATA_WIDTH-1:0] data_q;

   logic [DATA_WIDTH-1:0] lb0_q [IN_H_PIXEL];
   logic [DATA_WIDTH-1:0] lb1_q [IN_H_PIXEL];

   assign req    = (req_left_q != '0);
   assign wr_en  = bus.frame_i_valid && req_d1_q;
   assign accept = (state_q == S_IDLE) && frame_start && !busy_q;
   assign row_nx = row_q + ROWW'(1);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sel_q   <= 1'b0;
         row_q   <= '0;
         pix_q   <= '0;
         blank_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         row_q   <= row_d;
         pix_q   <= pix_d;
         blank_q <= blank_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      row_d      = row_q;
      pix_d      = pix_q;
      blank_d    = blank_q;
      load_fetch = 1'b0;
      fetch_buf  = sel_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d    = S_PRELOAD;
               row_d      = '0;
               load_fetch = 1'b1;
               fetch_buf  = sel_q;
            end
         end
         S_PRELOAD: begin
            if (wr_en && (wr_col_q == COL_LAST)) begin
               state_d = S_ROW_HS;
               // Row 1 streams into the other buffer during output row 0.
               if (IN_V_PIXEL > 1) begin
                  load_fetch = 1'b1;
                  fetch_buf  = ~sel_q;
               end
            end
         end
         S_ROW_HS: begin
            state_d = S_ROW_PIX;
            pix_d   = '0;
         end
         S_ROW_PIX: begin
            pix_d = pix_q + PW'(1);
            if (pix_q == PIX_LAST) begin
               state_d = S_ROW_BLANK;
               pix_d   = '0;
               blank_d = '0;
            end
         end
         S_ROW_BLANK: begin
            blank_d = blank_q + BKW'(1);
            if (blank_q == BLANK_LAST) begin
               blank_d = '0;
               if (row_q == ROW_LAST) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_ROW_HS;
                  row_d   = row_nx;
                  if (row_q[0]) begin
                     sel_d = ~sel_q;
                     if (row_nx[ROWW-1:1] < Y_LAST) begin
                        load_fetch = 1'b1;
                        fetch_buf  = sel_q;
                     end
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- fetch engine ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_left_q <= '0;
         wr_col_q   <= '0;
         wr_buf_q   <= 1'b0;
         req_d1_q   <= 1'b0;
      end else begin
         req_d1_q <= req;
         if (load_fetch) begin
            req_left_q <= REQ_ROW;
            wr_col_q   <= '0;
            wr_buf_q   <= fetch_buf;
         end else begin
            if (req) begin
               req_left_q <= req_left_q - QW'(1);
            end
            if (wr_en) begin
               wr_col_q <= wr_col_q + CW'(1);
            end
         end
      end
   end

   // Line-buffer contents need no reset; only the pointers around them do.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wr_buf_q) begin
            lb1_q[wr_col_q] <= bus.frame_i_data;
         end else begin
            lb0_q[wr_col_q] <= bus.frame_i_data;
         end
      end
   end

   // ---------------- interpolation ----------------
   function automatic logic [MW-1:0] blend(input logic [MW-1:0] p, input logic [MW-1:0] r,
                                           input logic [MW-1:0] d, input logic [MW-1:0] dr,
                                           input logic odd_x, input logic odd_y);
      logic [MW+1:0] s;
      logic [1:0]    sh;
      s  = {2'b00, p};
      sh = 2'd0;
      if (odd_x && odd_y) begin
         s  = {2'b00, p} + {2'b00, r} + {2'b00, d} + {2'b00, dr};
         sh = 2'd2;
      end else if (odd_x) begin
         s  = {2'b00, p} + {2'b00, r};
         sh = 2'd1;
      end else if (odd_y) begin
         s  = {2'b00, p} + {2'b00, d};
         sh = 2'd1;
      end
      return MW'(s >> sh);
   endfunction

   logic [CW-1:0]         x, xr;
   logic [YW-1:0]         y;
   logic                  dn_sel;
   logic [DATA_WIDTH-1:0] p_pix, r_pix, d_pix, dr_pix, pix_out;

   always_comb begin
      x       = pix_q[PW-1:1];
      y       = row_q[ROWW-1:1];
      xr      = (x == COL_LAST) ? x : x + CW'(1);
      // On the last input row the down neighbours replicate the current row.
      dn_sel  = (y == Y_LAST) ? sel_q : ~sel_q;
      p_pix   = sel_q  ? lb1_q[x]  : lb0_q[x];
      r_pix   = sel_q  ? lb1_q[xr] : lb0_q[xr];
      d_pix   = dn_sel ? lb1_q[x]  : lb0_q[x];
      dr_pix  = dn_sel ? lb1_q[xr] : lb0_q[xr];
      pix_out = '0;
      pix_out[R_LO +: RGB_R_WIDTH] = RGB_R_WIDTH'(blend(
         MW'(p_pix[R_LO +: RGB_R_WIDTH]), MW'(r_pix[R_LO +: RGB_R_WIDTH]),
         MW'(d_pix[R_LO +: RGB_R_WIDTH]), MW'(dr_pix[R_LO +: RGB_R_WIDTH]),
         pix_q[0], row_q[0]));
      pix_out[G_LO +: RGB_G_WIDTH] = RGB_G_WIDTH'(blend(
         MW'(p_pix[G_LO +: RGB_G_WIDTH]), MW'(r_pix[G_LO +: RGB_G_WIDTH]),
         MW'(d_pix[G_LO +: RGB_G_WIDTH]), MW'(dr_pix[G_LO +: RGB_G_WIDTH]),
         pix_q[0], row_q[0]));
      pix_out[B_LO +: RGB_B_WIDTH] = RGB_B_WIDTH'(blend(
         MW'(p_pix[B_LO +: RGB_B_WIDTH]), MW'(r_pix[B_LO +: RGB_B_WIDTH]),
         MW'(d_pix[B_LO +: RGB_B_WIDTH]), MW'(dr_pix[B_LO +: RGB_B_WIDTH]),
         pix_q[0], row_q[0]));
   end

   // ---------------- registered outputs ----------------
   // All framing outputs trail the FSM by one cycle, so they stay aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q    <= 1'b0;
         hs_q    <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         vs_q    <= (state_q == S_ROW_HS) && (row_q == '0);
         hs_q    <= (state_q == S_ROW_HS);
         valid_q <= (state_q == S_ROW_PIX);
         data_q  <= (state_q == S_ROW_PIX) ? pix_out : '0;
         busy_q  <= accept || (state_q != S_IDLE);
      end
   end

   assign bus.frame_i_req   = req;
   assign bus.frame_o_vs    = vs_q;
   assign bus.frame_o_hs    = hs_q;
   assign bus.frame_o_valid = valid_q;
   assign bus.frame_o_data  = data_q;
   assign busy              = busy_q;
   assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_bilinear_upscale_2x.sv
// Directed bench for bilinear_upscale_2x on a 4x2 input frame: golden gray
// frame, framing, channel independence, ignored restart, reset abort, stray valid.
module tb_bilinear_upscale_2x;

   localparam int DW = 24;
   localparam int IH = 4;
   localparam int IV = 2;
   localparam int HB = 4;

   logic       clk;
   logic       rst_n;
   logic       frame_start;
   logic       busy;
   logic [2:0] dbg_state;

   bilinear_upscale_2x_if #(.DATA_WIDTH(DW)) bus();

   bilinear_upscale_2x #(
      .DATA_WIDTH(DW), .RGB_R_WIDTH(8), .RGB_G_WIDTH(8), .RGB_B_WIDTH(8),
      .IN_H_PIXEL(IH), .IN_V_PIXEL(IV), .HBLANK(HB)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .frame_start(frame_start),
      .busy(busy),
      .bus(bus),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- shared state ----------------
   logic [DW-1:0] img [0:7];
   int            gold [0:3][0:7] = '{
      '{0, 8, 16, 24, 32, 40, 48, 48},
      '{32, 40, 48, 56, 64, 72, 80, 80},
      '{64, 72, 80, 88, 96, 104, 112, 112},
      '{64, 72, 80, 88, 96, 104, 112, 112}
   };
   logic [DW-1:0] out_pix [0:3][0:7];
   logic [31:0]   exp_q [$];

   int   n_checks, n_fail;
   int   cyc, req_cnt, vs_cnt, vs_bad, hs_cnt, gap_bad, noncontig;
   int   row_idx, col, last_valid_cyc, busy_gap;
   int   row_valid [0:3];
   logic prev_valid, prev_hs, prev_busy;
   int   rd_idx, inj_ctr;
   logic pending, inject;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- upstream reader model ----------------
   initial begin
      pending = 1'b0;
      inj_ctr = 0;
      bus.frame_i_valid = 1'b0;
      bus.frame_i_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         inj_ctr++;
         if (!rst_n) begin
            bus.frame_i_valid = 1'b0;
            bus.frame_i_data  = '0;
            pending = 1'b0;
         end else begin
            if (pending) begin
               bus.frame_i_valid = 1'b1;
               bus.frame_i_data  = img[rd_idx % 8];
               rd_idx++;
            end else if (inject && (inj_ctr % 3 == 0)) begin
               bus.frame_i_valid = 1'b1;
               bus.frame_i_data  = 24'hABCDEF;
            end else begin
               bus.frame_i_valid = 1'b0;
               bus.frame_i_data  = '0;
            end
            pending = bus.frame_i_req;
         end
      end
   end

   // ---------------- output monitor ----------------
   task automatic clear_mon();
      req_cnt = 0; vs_cnt = 0; vs_bad = 0; hs_cnt = 0; gap_bad = 0; noncontig = 0;
      row_idx = -1; col = 0; last_valid_cyc = 0; busy_gap = -1;
      for (int r = 0; r < 4; r++) begin
         row_valid[r] = 0;
         for (int c = 0; c < 8; c++) out_pix[r][c] = '1;
      end
   endtask

   initial begin
      cyc = 0;
      prev_valid = 1'b0; prev_hs = 1'b0; prev_busy = 1'b0;
      clear_mon();
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.frame_i_req) req_cnt++;
         if (bus.frame_o_vs) begin
            vs_cnt++;
            if (!bus.frame_o_hs || hs_cnt != 0) vs_bad++;
         end
         if (bus.frame_o_hs) begin
            if (hs_cnt > 0 && (cyc - last_valid_cyc - 1) != HB) gap_bad++;
            hs_cnt++;
            row_idx++;
            col = 0;
         end
         if (bus.frame_o_valid) begin
            if (col > 0 && !prev_valid) noncontig++;
            if (col == 0 && !prev_hs) noncontig++;
            if (row_idx >= 0 && row_idx < 4 && col < 8) begin
               out_pix[row_idx][col] = bus.frame_o_data;
               row_valid[row_idx]++;
            end
            col++;
            last_valid_cyc = cyc;
         end
         if (prev_busy && !busy) busy_gap = cyc - last_valid_cyc;
         prev_valid = bus.frame_o_valid;
         prev_hs    = bus.frame_o_hs;
         prev_busy  = busy;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_gray();
      for (int i = 0; i < 8; i++) img[i] = {3{8'(i * 16)}};
   endtask

   task automatic run_frame(input string f, input bit mid_pulse);
      bit seen, done;
      @(posedge clk);
      #1;
      clear_mon();
      rd_idx = 0;
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
      seen = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (mid_pulse && i == 25) frame_start = 1'b1;
         if (mid_pulse && i == 26) frame_start = 1'b0;
         if (busy) seen = 1'b1;
         else if (seen) begin
            done = 1'b1;
            break;
         end
      end
      frame_start = 1'b0;
      check({f, "_done"}, 32'(done), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_framing(input string f);
      check({f, "_vs_cnt"}, vs_cnt, 1);
      check({f, "_vs_with_first_hs"}, vs_bad, 0);
      check({f, "_hs_cnt"}, hs_cnt, 4);
      check({f, "_blank_gap"}, gap_bad, 0);
      check({f, "_contig"}, noncontig, 0);
      for (int r = 0; r < 4; r++) check($sformatf("%s_valid_r%0d", f, r), row_valid[r], 8);
      check({f, "_req_cnt"}, req_cnt, 8);
      check({f, "_busy_fall"}, busy_gap, HB + 1);
   endtask

   task automatic check_gray(input string f);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 8; c++) exp_q.push_back(32'({3{8'(gold[r][c])}}));
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 8; c++)
            check($sformatf("%s_px_r%0dc%0d", f, r, c), 32'(out_pix[r][c]), exp_q.pop_front());
   endtask

   task automatic check_idle_outputs(input string f);
      check({f, "_req"},   32'(bus.frame_i_req),   32'd0);
      check({f, "_vs"},    32'(bus.frame_o_vs),    32'd0);
      check({f, "_hs"},    32'(bus.frame_o_hs),    32'd0);
      check({f, "_valid"}, 32'(bus.frame_o_valid), 32'd0);
      check({f, "_data"},  32'(bus.frame_o_data),  32'd0);
      check({f, "_busy"},  32'(busy),              32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int req_base;
      bit hit;
      n_checks = 0;
      n_fail   = 0;
      rd_idx   = 0;
      inject   = 1'b0;
      rst_n    = 1'b0;
      frame_start = 1'b0;
      load_gray();
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      check("reset_state", 32'(dbg_state), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Golden gray frame with full framing checks
      run_frame("f1", 1'b0);
      check_framing("f1");
      check_gray("f1");

      // frame_start pulsed mid-frame must not restart or add requests
      run_frame("f2", 1'b1);
      check_framing("f2");
      check_gray("f2");

      // Stray upstream valids without a request are ignored
      inject = 1'b1;
      run_frame("f3", 1'b0);
      inject = 1'b0;
      check_framing("f3");
      check_gray("f3");

      // Channel independence: per-channel truncating averages
      img[0] = 24'hFF0001; img[1] = 24'h01FF00; img[2] = 24'h0; img[3] = 24'h0;
      for (int i = 4; i < 8; i++) img[i] = 24'h0;
      run_frame("f4", 1'b0);
      check("f4_req_cnt", req_cnt, 8);
      exp_q.push_back(32'hFF0001);
      exp_q.push_back(32'h807F00);
      exp_q.push_back(32'h01FF00);
      exp_q.push_back(32'h007F00);
      exp_q.push_back(32'h403F00);
      check("f4_px_r0c0", 32'(out_pix[0][0]), exp_q.pop_front());
      check("f4_px_r0c1", 32'(out_pix[0][1]), exp_q.pop_front());
      check("f4_px_r0c2", 32'(out_pix[0][2]), exp_q.pop_front());
      check("f4_px_r0c3", 32'(out_pix[0][3]), exp_q.pop_front());
      check("f4_px_r1c1", 32'(out_pix[1][1]), exp_q.pop_front());

      // Reset asserted during output row 1 aborts at once
      load_gray();
      @(posedge clk);
      #1;
      clear_mon();
      rd_idx = 0;
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (row_idx == 1 && col >= 3) begin
            hit = 1'b1;
            break;
         end
      end
      check("rst_reached_row1", 32'(hit), 32'd1);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("rst_mid");
      req_base = req_cnt;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("rst_no_req_after", req_cnt - req_base, 0);
      check("rst_busy_after", 32'(busy), 32'd0);
      check("rst_state_after", 32'(dbg_state), 32'd0);

      // Full frame after the abort
      run_frame("f5", 1'b0);
      check_framing("f5");
      check_gray("f5");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
